// File: rtl/toy_mem_port_arbiter.sv
// Shares one single-port memory between the fetch (I, read-only) and MEM (D, read/write) sides.
// Define TOY_ARB_RR_EN for round-robin arbitration; default is D priority with an I starvation guard.
module toy_mem_port_arbiter #(
    parameter int AW          = 30,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_GNT,
    output logic          I_RVALID,
    output logic [DW-1:0] I_RDATA,
    input  logic          D_REQ,
    input  logic          D_RW,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_RVALID,
    output logic [DW-1:0] D_RDATA,
    output logic          M_REQ,
    output logic          M_RW,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic          M_RDY,
    input  logic          M_RVALID,
    input  logic [DW-1:0] M_RDATA,
    output logic          ERR
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTANDING);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tags_q [OUTSTANDING];
    logic          err_q, err_d;
    logic          full, empty, i_elig, d_elig, sel_i, sel_d;
    logic          i_acc, d_acc, push, pop, head_is_d;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign full   = (cnt_q == FULL_CNT);
    assign empty  = (cnt_q == '0);
    assign i_elig = ~RST & I_REQ & ~full;
    assign d_elig = ~RST & D_REQ & (D_RW | ~full);

`ifdef TOY_ARB_RR_EN
    logic prio_d_q, prio_d_d;

    assign sel_i    = i_elig & (~d_elig | ~prio_d_q);
    assign prio_d_d = i_acc ? 1'b1 : (d_acc ? 1'b0 : prio_d_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) prio_d_q <= 1'b1;
        else     prio_d_q <= prio_d_d;
    end
`else
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STV = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    assign sel_i = i_elig & (~d_elig | (starve_q == STV));

    always_comb begin
        starve_d = starve_q;
        if (!I_REQ || i_acc)
            starve_d = '0;
        else if (i_elig && !sel_i && starve_q != STV)
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    assign sel_d = d_elig & ~sel_i;
    assign i_acc = sel_i & M_RDY;
    assign d_acc = sel_d & M_RDY;

    assign M_REQ   = i_elig | d_elig;
    assign M_RW    = sel_d & D_RW;
    assign M_ADDR  = sel_i ? I_ADDR : (sel_d ? D_ADDR : '0);
    assign M_WDATA = sel_d ? D_WDATA : '0;
    assign I_GNT   = i_acc;
    assign D_GNT   = d_acc;

    // Tag 0 = I, 1 = D; returns are in order so the head tag names the owner.
    assign push      = i_acc | (d_acc & ~D_RW);
    assign pop       = ~RST & M_RVALID & ~empty;
    assign head_is_d = tags_q[rd_ptr_q];

    assign I_RVALID = pop & ~head_is_d;
    assign D_RVALID = pop & head_is_d;
    assign I_RDATA  = I_RVALID ? M_RDATA : '0;
    assign D_RDATA  = D_RVALID ? M_RDATA : '0;
    assign ERR      = err_q;

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
    assign err_d    = err_q | (~RST & M_RVALID & empty);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) tags_q[wr_ptr_q] <= sel_d;
    end

endmodule

// File: tb/tb_toy_mem_port_arbiter.sv
// Scoreboard bench for toy_mem_port_arbiter: grants checked inline, read returns checked by a monitor.
module tb_toy_mem_port_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          I_REQ, I_GNT, I_RVALID;
    logic [AW-1:0] I_ADDR;
    logic [DW-1:0] I_RDATA;
    logic          D_REQ, D_RW, D_GNT, D_RVALID;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA, D_RDATA;
    logic          M_REQ, M_RW, M_RDY, M_RVALID, ERR;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_WDATA, M_RDATA;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    toy_mem_port_arbiter dut (
        .CLK(clk), .RST(rst),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT),
        .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDY(M_RDY),
        .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .ERR(ERR)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        I_REQ = 1'b0; I_ADDR = '0;
        D_REQ = 1'b0; D_RW = 1'b0; D_ADDR = '0; D_WDATA = '0;
        M_RDY = 1'b1; M_RVALID = 1'b0; M_RDATA = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic owner_d, input logic [31:0] data);
        nxt(); idle();
        M_RVALID = 1'b1; M_RDATA = data;
        exp_q.push_back({owner_d, data});
    endtask

    // Monitor: every read return must match the head of the expected-response queue.
    always @(negedge clk) begin
        logic [32:0] e;
        if (I_RVALID === 1'b1 || D_RVALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: I_RVALID=%b D_RVALID=%b expected none at %0t",
                         I_RVALID, D_RVALID, $time);
            end else begin
                e = exp_q.pop_front();
                chk1("rsp_d_rvalid", D_RVALID, e[32]);
                chk1("rsp_i_rvalid", I_RVALID, ~e[32]);
                chk32("rsp_data", e[32] ? D_RDATA : I_RDATA, e[31:0]);
                chk32("rsp_other_rdata_zero", e[32] ? I_RDATA : D_RDATA, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev_d, exp_d;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #4;
        chk1("rst_m_req", M_REQ, 1'b0);
        chk1("rst_i_gnt", I_GNT, 1'b0);
        chk1("rst_d_gnt", D_GNT, 1'b0);
        chk1("rst_err", ERR, 1'b0);
        chk1("rst_i_rvalid", I_RVALID, 1'b0);
        nxt(); rst = 1'b0;

        // Lone fetch, data returned next cycle
        nxt(); I_REQ = 1'b1; I_ADDR = 30'h10; #3;
        chk1("t2_m_req", M_REQ, 1'b1);
        chk32("t2_m_addr", {2'b00, M_ADDR}, 32'h10);
        chk1("t2_i_gnt", I_GNT, 1'b1);
        chk1("t2_d_gnt", D_GNT, 1'b0);
        chk1("t2_m_rw", M_RW, 1'b0);
        ret(1'b0, 32'hDEADBEEF); #3;
        chk1("t2_i_rvalid", I_RVALID, 1'b1);
        chk1("t2_d_rvalid", D_RVALID, 1'b0);
        nxt(); idle();

        // Mixed-owner returns: I, D, I
        nxt(); I_REQ = 1'b1; I_ADDR = 30'h1; #3;
        chk1("t4_gnt0_i", I_GNT, 1'b1);
        nxt(); idle(); D_REQ = 1'b1; D_ADDR = 30'h2; #3;
        chk1("t4_gnt1_d", D_GNT, 1'b1);
        nxt(); idle(); I_REQ = 1'b1; I_ADDR = 30'h3; #3;
        chk1("t4_gnt2_i", I_GNT, 1'b1);
        ret(1'b0, 32'h1);
        ret(1'b1, 32'h2);
        ret(1'b0, 32'h3);
        nxt(); idle();

        // Both sides request every cycle, memory returns each read one cycle later
        prev_d = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nxt(); idle();
            I_REQ = 1'b1; I_ADDR = 30'h100 + 30'(k);
            D_REQ = 1'b1; D_ADDR = 30'h200 + 30'(k);
            if (k > 0) begin
                M_RVALID = 1'b1; M_RDATA = 32'h300 + 32'(k);
                exp_q.push_back({prev_d, 32'h300 + 32'(k)});
            end
`ifdef TOY_ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = (k % 4 != 3);
`endif
            #3;
            chk1("t3_d_gnt", D_GNT, exp_d);
            chk1("t3_i_gnt", I_GNT, ~exp_d);
            chk32("t3_m_addr", {2'b00, M_ADDR}, exp_d ? 32'h200 + 32'(k) : 32'h100 + 32'(k));
            prev_d = exp_d;
        end
        ret(prev_d, 32'h308);
        nxt(); idle();

        // Fill the tag FIFO: I, D, I, D with no returns
        for (int j = 0; j < 4; j++) begin
            nxt(); idle();
            if (j % 2 == 0) begin I_REQ = 1'b1; I_ADDR = 30'h40 + 30'(j); end
            else begin D_REQ = 1'b1; D_ADDR = 30'h40 + 30'(j); end
            #3;
            chk1("t5_fill_gnt", (j % 2 == 0) ? I_GNT : D_GNT, 1'b1);
        end
        nxt(); idle(); I_REQ = 1'b1; I_ADDR = 30'h50; #3;
        chk1("t5_full_i_gnt", I_GNT, 1'b0);
        chk1("t5_full_m_req", M_REQ, 1'b0);
        nxt(); I_REQ = 1'b1; I_ADDR = 30'h50;
        D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h20; D_WDATA = 32'h55; #3;
        chk1("t5_wr_d_gnt", D_GNT, 1'b1);
        chk1("t5_wr_m_rw", M_RW, 1'b1);
        chk32("t5_wr_m_addr", {2'b00, M_ADDR}, 32'h20);
        chk32("t5_wr_m_wdata", M_WDATA, 32'h55);
        chk1("t5_wr_i_gnt", I_GNT, 1'b0);
        ret(1'b0, 32'hA0); I_REQ = 1'b1; I_ADDR = 30'h50; #3;
        chk1("t5_pop_same_cycle_i_gnt", I_GNT, 1'b0);
        chk1("t5_pop_same_cycle_m_req", M_REQ, 1'b0);
        nxt(); idle(); I_REQ = 1'b1; I_ADDR = 30'h50; #3;
        chk1("t5_after_pop_i_gnt", I_GNT, 1'b1);
        chk32("t5_after_pop_m_addr", {2'b00, M_ADDR}, 32'h50);
        ret(1'b1, 32'hB0);
        ret(1'b0, 32'hC0);
        ret(1'b1, 32'hD0);
        ret(1'b0, 32'hE0);
        nxt(); idle();

        // Memory stall with D read held
        for (int s = 0; s < 5; s++) begin
            nxt(); idle(); M_RDY = 1'b0; D_REQ = 1'b1; D_ADDR = 30'h60; #3;
            chk1("t6_stall_m_req", M_REQ, 1'b1);
            chk1("t6_stall_d_gnt", D_GNT, 1'b0);
        end
        nxt(); idle(); D_REQ = 1'b1; D_ADDR = 30'h60; #3;
        chk1("t6_release_d_gnt", D_GNT, 1'b1);
        ret(1'b1, 32'h66); #3;
        chk1("t6_err_clear", ERR, 1'b0);
        nxt(); idle(); M_RVALID = 1'b1; M_RDATA = 32'h77; #3;
        chk1("t6_empty_i_rvalid", I_RVALID, 1'b0);
        chk1("t6_empty_d_rvalid", D_RVALID, 1'b0);
        nxt(); idle(); #3;
        chk1("t6_err_set", ERR, 1'b1);

        // Reset with two reads in flight
        nxt(); idle(); I_REQ = 1'b1; I_ADDR = 30'h70; #3;
        chk1("t1_i_gnt", I_GNT, 1'b1);
        nxt(); idle(); D_REQ = 1'b1; D_ADDR = 30'h71; #3;
        chk1("t1_d_gnt", D_GNT, 1'b1);
        nxt(); idle(); rst = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'h88; #3;
        chk1("t1_rst_m_req", M_REQ, 1'b0);
        chk1("t1_rst_i_rvalid", I_RVALID, 1'b0);
        chk1("t1_rst_d_rvalid", D_RVALID, 1'b0);
        chk1("t1_rst_err", ERR, 1'b0);
        chk32("t1_rst_m_addr", {2'b00, M_ADDR}, 32'h0);
        nxt(); idle();
        nxt(); rst = 1'b0;
        nxt(); idle(); M_RVALID = 1'b1; M_RDATA = 32'h99; #3;
        chk1("t1_post_i_rvalid", I_RVALID, 1'b0);
        chk1("t1_post_d_rvalid", D_RVALID, 1'b0);
        chk32("t1_post_i_rdata", I_RDATA, 32'h0);
        nxt(); idle(); #3;
        chk1("t1_post_err", ERR, 1'b1);

        nxt();
        chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
